// File: rtl/pcfx_bk_ctrl_if.sv
// Host SD-image side of the backup-RAM persistence controller.
// Carries the mount notification (img_*), the sector request handshake
// (sd_lba/sd_rd/sd_wr/sd_ack) and the per-word buffer bus (sd_buff_*).
//   master : the backup controller (issues sector requests, supplies save data)
//   slave  : the host image interface (acknowledges, streams load data)
interface pcfx_bk_ctrl_if;
  logic [1:0]  img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic [1:0]  sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din;

  modport master (
    input  img_mounted, img_readonly, img_size,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  modport slave (
    output img_mounted, img_readonly, img_size,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  sd_lba, sd_rd, sd_wr, sd_buff_din
  );
endinterface

// File: rtl/pcfx_bk_ctrl.sv
// PC-FX backup-RAM persistence controller.
// Moves disk 0 (internal backup SRAM) and disk 1 (external FX-BMP memory)
// between one port of the dual-port backup RAM and the host's sector-based
// SD image interface, as whole-image load or save sequences.
// Ports:
//   clk_sys, reset_n     : clock, asynchronous active-low reset
//   sd                   : host image interface (master side)
//   bk_load, bk_save     : level requests; a rising edge while idle starts a sequence
//   bk_ena               : at least one disk image is mounted
//   bk_loading/bk_saving : a load / save sequence is in progress
//   mem_sel              : RAM select, 0 = internal, 1 = external
//   mem_addr/mem_wdata/mem_we/mem_rdata : backup RAM port (1-cycle read latency)
module pcfx_bk_ctrl #(
  parameter int INT_SECTORS = 64,
  parameter int EXT_SECTORS = 256
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  pcfx_bk_ctrl_if.master sd,
  input  logic           bk_load,
  input  logic           bk_save,
  output logic           bk_ena,
  output logic           bk_loading,
  output logic           bk_saving,
  output logic           mem_sel,
  output logic [15:0]    mem_addr,
  output logic [15:0]    mem_wdata,
  output logic           mem_we,
  input  logic [15:0]    mem_rdata
);

  localparam logic [8:0] INT_CAP = 9'(INT_SECTORS);
  localparam logic [8:0] EXT_CAP = 9'(EXT_SECTORS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_REQ  = 3'd2,
    ST_XFER = 3'd3,
    ST_ADV  = 3'd4
  } state_t;

  // Image size in bytes -> sector count, limited to the disk capacity.
  // Anything at or above 2^18 bytes is over every capacity.
  function automatic logic [8:0] clamp_sectors(input logic [63:0] size, input logic [8:0] cap);
    logic [8:0] n;
    if (|size[63:18]) begin
      n = cap;
    end else if (size[17:9] > cap) begin
      n = cap;
    end else begin
      n = size[17:9];
    end
    return n;
  endfunction

  state_t      state_r, state_s;
  logic        disk_r, disk_s;
  logic [1:0]  sel_idx_r, sel_idx_s;   // next disk SEL may consider (2 = none left)
  logic [7:0]  sector_r, sector_s;
  logic        start_load_s, start_save_s;
  logic        dir_save_r;

  logic [8:0]  nsec0_r, nsec1_r;
  logic [1:0]  ro_r;
  logic [8:0]  run_nsec0_r, run_nsec1_r;
  logic [1:0]  run_ro_r;

  logic        load_d_r, save_d_r;
  logic        load_rise_s, save_rise_s;
  logic        ok0_s, ok1_s;
  logic        ack_cur_s;
  logic [8:0]  cur_nsec_s;
  logic [1:0]  req_bits_s;

  logic [31:0] sd_lba_r;
  logic [1:0]  sd_rd_r, sd_wr_r;
  logic        bk_ena_r, loading_r, saving_r, mem_sel_r;
  logic [15:0] buff_din_s;
  logic [7:0]  addr_sector_s;
  logic        unused_size_bits;

  assign unused_size_bits = ^sd.img_size[8:0];

  assign load_rise_s = bk_load & ~load_d_r;
  assign save_rise_s = bk_save & ~save_d_r;

  // Eligibility uses the snapshot taken at sequence start, so a mount pulse
  // arriving mid-sequence only affects the next sequence.
  assign ok0_s      = (run_nsec0_r != 9'd0) & ~(dir_save_r & run_ro_r[0]);
  assign ok1_s      = (run_nsec1_r != 9'd0) & ~(dir_save_r & run_ro_r[1]);
  assign ack_cur_s  = sd.sd_ack[disk_r];
  assign cur_nsec_s = disk_r ? run_nsec1_r : run_nsec0_r;
  assign req_bits_s = disk_s ? 2'b10 : 2'b01;

  // Next-state logic for the sequencer.
  always_comb begin
    state_s      = state_r;
    disk_s       = disk_r;
    sel_idx_s    = sel_idx_r;
    sector_s     = sector_r;
    start_load_s = 1'b0;
    start_save_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sel_idx_s = 2'd0;
        sector_s  = 8'd0;
        if (load_rise_s) begin
          start_load_s = 1'b1;
          state_s      = ST_SEL;
        end else if (save_rise_s) begin
          start_save_s = 1'b1;
          state_s      = ST_SEL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEL: begin
        sector_s = 8'd0;
        if ((sel_idx_r == 2'd0) && ok0_s) begin
          disk_s    = 1'b0;
          sel_idx_s = 2'd1;
          state_s   = ST_REQ;
        end else if ((sel_idx_r != 2'd2) && ok1_s) begin
          disk_s    = 1'b1;
          sel_idx_s = 2'd2;
          state_s   = ST_REQ;
        end else begin
          sel_idx_s = 2'd2;
          state_s   = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_cur_s) begin
          state_s = ST_XFER;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_XFER: begin
        if (!ack_cur_s) begin
          state_s = ST_ADV;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_ADV: begin
        // 9-bit compare: sector + 1 reaching nsec (up to 256) ends the disk
        // without the 8-bit counter ever wrapping.
        if (({1'b0, sector_r} + 9'd1) < cur_nsec_s) begin
          sector_s = sector_r + 8'd1;
          state_s  = ST_REQ;
        end else begin
          sector_s = 8'd0;
          state_s  = ST_SEL;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, current disk and sector.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      disk_r     <= 1'b0;
      sel_idx_r  <= 2'd0;
      sector_r   <= 8'd0;
      dir_save_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      disk_r    <= disk_s;
      sel_idx_r <= sel_idx_s;
      sector_r  <= sector_s;
      if (start_save_s) begin
        dir_save_r <= 1'b1;
      end else if (start_load_s) begin
        dir_save_r <= 1'b0;
      end else begin
        dir_save_r <= dir_save_r;
      end
    end
  end

  // Mount latches and the per-sequence snapshot of them.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      nsec0_r     <= 9'd0;
      nsec1_r     <= 9'd0;
      ro_r        <= 2'b00;
      run_nsec0_r <= 9'd0;
      run_nsec1_r <= 9'd0;
      run_ro_r    <= 2'b00;
    end else begin
      if (sd.img_mounted[0]) begin
        nsec0_r <= clamp_sectors(sd.img_size, INT_CAP);
        ro_r[0] <= sd.img_readonly;
      end else begin
        nsec0_r <= nsec0_r;
        ro_r[0] <= ro_r[0];
      end
      if (sd.img_mounted[1]) begin
        nsec1_r <= clamp_sectors(sd.img_size, EXT_CAP);
        ro_r[1] <= sd.img_readonly;
      end else begin
        nsec1_r <= nsec1_r;
        ro_r[1] <= ro_r[1];
      end
      if (start_load_s || start_save_s) begin
        run_nsec0_r <= nsec0_r;
        run_nsec1_r <= nsec1_r;
        run_ro_r    <= ro_r;
      end else begin
        run_nsec0_r <= run_nsec0_r;
        run_nsec1_r <= run_nsec1_r;
        run_ro_r    <= run_ro_r;
      end
    end
  end

  // Registered status, request and select outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      load_d_r  <= 1'b0;
      save_d_r  <= 1'b0;
      bk_ena_r  <= 1'b0;
      sd_rd_r   <= 2'b00;
      sd_wr_r   <= 2'b00;
      sd_lba_r  <= 32'd0;
      loading_r <= 1'b0;
      saving_r  <= 1'b0;
      mem_sel_r <= 1'b0;
    end else begin
      load_d_r <= bk_load;
      save_d_r <= bk_save;
      bk_ena_r <= (nsec0_r != 9'd0) | (nsec1_r != 9'd0);
      // The request is held only while REQ persists, so it drops the cycle
      // after the acknowledge is seen.
      if ((state_s == ST_REQ) && !dir_save_r) begin
        sd_rd_r <= req_bits_s;
      end else begin
        sd_rd_r <= 2'b00;
      end
      if ((state_s == ST_REQ) && dir_save_r) begin
        sd_wr_r <= req_bits_s;
      end else begin
        sd_wr_r <= 2'b00;
      end
      if (state_s == ST_REQ) begin
        sd_lba_r <= {24'd0, sector_s};
      end else begin
        sd_lba_r <= sd_lba_r;
      end
      if (start_load_s) begin
        loading_r <= 1'b1;
      end else if (state_s == ST_IDLE) begin
        loading_r <= 1'b0;
      end else begin
        loading_r <= loading_r;
      end
      if (start_save_s) begin
        saving_r <= 1'b1;
      end else if (state_s == ST_IDLE) begin
        saving_r <= 1'b0;
      end else begin
        saving_r <= saving_r;
      end
      if (state_s == ST_IDLE) begin
        mem_sel_r <= 1'b0;
      end else begin
        mem_sel_r <= disk_s;
      end
    end
  end

  // RAM port: address tracks the host word index directly (the host holds
  // each save address long enough to cover the RAM latency); writes happen
  // in the same cycle as the host strobe.
  always_comb begin
    mem_we        = 1'b0;
    mem_wdata     = 16'd0;
    mem_addr      = 16'd0;
    buff_din_s    = 16'd0;
    addr_sector_s = disk_r ? sector_r : {2'b00, sector_r[5:0]};
    if (state_r != ST_IDLE) begin
      mem_addr = {addr_sector_s, sd.sd_buff_addr};
    end else begin
      mem_addr = 16'd0;
    end
    if ((state_r == ST_XFER) && !dir_save_r && ack_cur_s && sd.sd_buff_wr) begin
      mem_we    = 1'b1;
      mem_wdata = sd.sd_buff_dout;
    end else begin
      mem_we    = 1'b0;
      mem_wdata = 16'd0;
    end
    if (saving_r) begin
      buff_din_s = mem_rdata;
    end else begin
      buff_din_s = 16'd0;
    end
  end

  assign sd.sd_lba      = sd_lba_r;
  assign sd.sd_rd       = sd_rd_r;
  assign sd.sd_wr       = sd_wr_r;
  assign sd.sd_buff_din = buff_din_s;
  assign bk_ena         = bk_ena_r;
  assign bk_loading     = loading_r;
  assign bk_saving      = saving_r;
  assign mem_sel        = mem_sel_r;

endmodule

// File: tb/tb_pcfx_bk_ctrl.sv
// Self-checking bench for pcfx_bk_ctrl: a scenario table (mounts, direction,
// expected request counts) plus hand-written sequences for simultaneous
// requests, level hold and reset abort. Expected sector requests go into a
// scoreboard queue when a sequence is started and are popped as the DUT asks.
module tb_pcfx_bk_ctrl;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        bk_load, bk_save;
  logic        bk_ena, bk_loading, bk_saving;
  logic        mem_sel, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  pcfx_bk_ctrl_if sd_if();

  pcfx_bk_ctrl #(.INT_SECTORS(64), .EXT_SECTORS(256)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sd(sd_if),
    .bk_load(bk_load), .bk_save(bk_save), .bk_ena(bk_ena),
    .bk_loading(bk_loading), .bk_saving(bk_saving), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  // Backup RAM model: preload an address pattern at the first edge.
  logic [15:0] int_ram [0:16383];
  logic [15:0] ext_ram [0:65535];
  logic        preloaded = 1'b0;

  function automatic logic [15:0] pre_pat(input logic d, input logic [15:0] a);
    return d ? (a ^ 16'hC3FF) : ({2'b00, a[13:0]} ^ 16'h3C00);
  endfunction

  function automatic logic [15:0] load_pat(input logic [15:0] seed, input logic d,
                                           input logic [7:0] lba, input logic [7:0] a);
    return {lba, a} ^ seed ^ (d ? 16'h00FF : 16'h0000);
  endfunction

  always @(posedge clk_sys) begin
    if (!preloaded) begin
      for (int i = 0; i < 16384; i++) int_ram[i] <= pre_pat(1'b0, 16'(i));
      for (int i = 0; i < 65536; i++) ext_ram[i] <= pre_pat(1'b1, 16'(i));
      preloaded <= 1'b1;
    end else if (mem_we) begin
      if (mem_sel) ext_ram[mem_addr] <= mem_wdata;
      else         int_ram[mem_addr[13:0]] <= mem_wdata;
    end
    mem_rdata <= mem_sel ? ext_ram[mem_addr] : int_ram[mem_addr[13:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        d;
    logic [31:0] lba;
  } req_t;
  req_t exp_q[$];

  typedef struct {
    logic [63:0] size0;
    logic [63:0] size1;
    logic        ro1;
    logic        save;
    logic        full;
    int          n0;
    int          n1;
    logic        ena;
  } scen_t;
  scen_t tbl[7];

  logic [7:0]  sparse [4];
  logic [15:0] cur_seed;
  logic        cur_full;

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    bk_load = 1'b0; bk_save = 1'b0;
    sd_if.img_mounted = 2'b00; sd_if.img_readonly = 1'b0; sd_if.img_size = 64'd0;
    sd_if.sd_ack = 2'b00; sd_if.sd_buff_addr = 8'd0; sd_if.sd_buff_dout = 16'd0;
    sd_if.sd_buff_wr = 1'b0;
    exp_q.delete();
    tick();
    check("reset_sd", {28'd0, sd_if.sd_rd, sd_if.sd_wr, sd_if.sd_lba}, 64'd0);
    check("reset_ctrl", {bk_ena, bk_loading, bk_saving, mem_sel, mem_we, mem_addr,
                         mem_wdata, sd_if.sd_buff_din}, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic mount(input logic d, input logic [63:0] size, input logic ro);
    sd_if.img_mounted  = d ? 2'b10 : 2'b01;
    sd_if.img_size     = size;
    sd_if.img_readonly = ro;
    tick();
    sd_if.img_mounted  = 2'b00;
  endtask

  task automatic push_reqs(input logic wr, input logic d, input int n);
    for (int l = 0; l < n; l++) begin
      req_t r;
      r.wr = wr; r.d = d; r.lba = 32'(l);
      exp_q.push_back(r);
    end
  endtask

  // Host side of one sector transfer, entered at the negedge a request is seen.
  task automatic serve_one();
    logic        d, wr;
    logic [31:0] lba;
    logic [7:0]  a;
    logic [15:0] got;
    req_t        e;
    d   = sd_if.sd_rd[1] | sd_if.sd_wr[1];
    wr  = |sd_if.sd_wr;
    lba = sd_if.sd_lba;
    if (exp_q.size() == 0) begin
      check("sb_extra_req", {60'd0, sd_if.sd_rd, sd_if.sd_wr}, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("req_bits", {60'd0, sd_if.sd_rd, sd_if.sd_wr},
            e.wr ? {62'd0, (e.d ? 2'b10 : 2'b01)} : {60'd0, (e.d ? 2'b10 : 2'b01), 2'b00});
      check("req_lba", lba, e.lba);
    end
    sd_if.sd_ack = d ? 2'b10 : 2'b01;
    tick();
    check("req_drop", {60'd0, sd_if.sd_rd, sd_if.sd_wr}, 64'd0);
    if (!wr) begin
      for (int k = 0; k < 4; k++) begin
        a = sparse[k];
        sd_if.sd_buff_addr = a;
        sd_if.sd_buff_dout = load_pat(cur_seed, d, lba[7:0], a);
        sd_if.sd_buff_wr   = 1'b1;
        tick();
        sd_if.sd_buff_wr   = 1'b0;
        got = d ? ext_ram[{lba[7:0], a}] : int_ram[{lba[5:0], a}];
        check("load_ram", got, load_pat(cur_seed, d, lba[7:0], a));
      end
    end else begin
      for (int k = 0; k < (cur_full ? 256 : 4); k++) begin
        a = cur_full ? 8'(k) : sparse[k];
        sd_if.sd_buff_addr = a;
        tick();
        tick();
        check("save_din", sd_if.sd_buff_din,
              d ? pre_pat(1'b1, {lba[7:0], a}) : pre_pat(1'b0, {2'b00, lba[5:0], a}));
      end
    end
    sd_if.sd_ack = 2'b00;
  endtask

  task automatic run_seq();
    int idle;
    idle = 0;
    forever begin
      tick();
      if (!(bk_loading | bk_saving)) break;
      if ((|sd_if.sd_rd) | (|sd_if.sd_wr)) begin
        serve_one();
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 200) begin
        check("seq_timeout", {62'd0, bk_loading, bk_saving}, 64'd0);
        break;
      end
    end
    check("sb_left", 64'(exp_q.size()), 64'd0);
    check("busy_fall", {62'd0, bk_loading, bk_saving}, 64'd0);
  endtask

  task automatic run_scenario(input int k);
    scen_t s;
    s = tbl[k];
    do_reset();
    mount(1'b0, s.size0, 1'b0);
    mount(1'b1, s.size1, s.ro1);
    tick(); tick();
    check("bk_ena", {63'd0, bk_ena}, {63'd0, s.ena});
    push_reqs(s.save, 1'b0, s.n0);
    push_reqs(s.save, 1'b1, s.n1);
    cur_seed = 16'h9E37 ^ 16'(k * 16'h0111);
    cur_full = s.full;
    if (s.save) bk_save = 1'b1; else bk_load = 1'b1;
    tick();
    bk_save = 1'b0; bk_load = 1'b0;
    check("busy_rise", {62'd0, bk_loading, bk_saving}, s.save ? 64'd1 : 64'd2);
    run_seq();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    sparse = '{8'd0, 8'd1, 8'd170, 8'd255};
    //            size0            size1                 ro1   save  full  n0  n1   ena
    tbl[0] = '{64'd2048,        64'd1536,             1'b0, 1'b1, 1'b1, 4,  3,   1'b1};
    tbl[1] = '{64'd2048,        64'd2048,             1'b1, 1'b1, 1'b1, 4,  0,   1'b1};
    tbl[2] = '{64'd32768,       64'd131072,           1'b0, 1'b0, 1'b0, 64, 256, 1'b1};
    tbl[3] = '{64'd8192,        64'd0,                1'b0, 1'b0, 1'b0, 16, 0,   1'b1};
    tbl[4] = '{64'd1048576,     64'd600,              1'b0, 1'b0, 1'b0, 64, 1,   1'b1};
    tbl[5] = '{64'd0,           64'd511,              1'b0, 1'b0, 1'b0, 0,  0,   1'b0};
    tbl[6] = '{64'd0,           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, 256, 1'b1};

    reset_n = 1'b0; bk_load = 1'b0; bk_save = 1'b0;
    sd_if.img_mounted = 2'b00; sd_if.img_readonly = 1'b0; sd_if.img_size = 64'd0;
    sd_if.sd_ack = 2'b00; sd_if.sd_buff_addr = 8'd0; sd_if.sd_buff_dout = 16'd0;
    sd_if.sd_buff_wr = 1'b0;
    cur_seed = 16'd0; cur_full = 1'b0;
    tick(); tick();

    for (int k = 0; k < 7; k++) run_scenario(k);

    // Load and save rise together, load held high past the end: one load only.
    do_reset();
    mount(1'b0, 64'd2048, 1'b0);
    tick();
    push_reqs(1'b0, 1'b0, 4);
    cur_seed = 16'h5A5A; cur_full = 1'b0;
    bk_load = 1'b1; bk_save = 1'b1;
    tick();
    bk_save = 1'b0;
    check("both_rise", {62'd0, bk_loading, bk_saving}, 64'd2);
    run_seq();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | (|sd_if.sd_rd) | (|sd_if.sd_wr) | bk_loading | bk_saving;
    end
    check("no_retrigger", {63'd0, seen}, 64'd0);
    bk_load = 1'b0;

    // Reset in the middle of a transfer aborts at once and forgets mounts.
    do_reset();
    mount(1'b0, 64'd32768, 1'b0);
    tick(); tick();
    bk_load = 1'b1;
    tick();
    bk_load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (|sd_if.sd_rd) break;
      tick();
    end
    check("abort_first_req", {62'd0, sd_if.sd_rd}, 64'd1);
    sd_if.sd_ack = 2'b01;
    tick(); tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_sd", {60'd0, sd_if.sd_rd, sd_if.sd_wr}, 64'd0);
    check("abort_status", {61'd0, bk_loading, bk_saving, bk_ena}, 64'd0);
    sd_if.sd_ack = 2'b00;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    bk_load = 1'b1;
    tick();
    bk_load = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | (|sd_if.sd_rd);
    end
    check("no_load_unmounted", {63'd0, seen}, 64'd0);
    check("ena_after_reset", {63'd0, bk_ena}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
